// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP receive parser.
// Frame field values, parser states and the queued result entry.
package arp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HEAD,
        VLAN,
        ARP_DATA,
        WAIT_EOF,
        DISCARD
    } state_t;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETH_TYPE_VLAN  = 16'h8100;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam logic [47:0] ETH_BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

    localparam logic [7:0] PRE_BYTE  = 8'h55;
    localparam logic [7:0] SFD_BYTE  = 8'hD5;
    localparam logic [7:0] ARP_HLEN  = 8'd6;
    localparam logic [7:0] ARP_PLEN  = 8'd4;

    typedef struct packed {
        logic        op;
        logic        grat;
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_entry_t;

endpackage

// File: rtl/arp_rx_q_fifo.sv
// Result queue of parsed ARP entries.
// A push into a full queue is taken when a pop happens in the same cycle.
import arp_pkg::*;

module arp_entry_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  arp_entry_t wdata,
    input  logic       pop,
    output arp_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    arp_entry_t    mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so reset leaves all outputs at 0.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/arp_rx_q.sv
// GMII ARP receive parser: preamble, Ethernet/802.1Q and ARP header
// checks, commit at clean end of frame into a result queue, statistics.
import arp_pkg::*;

module arp_rx_q #(
    parameter int QUEUE_DEPTH       = 4,
    parameter bit ACCEPT_VLAN       = 1'b1,
    parameter bit ACCEPT_GRATUITOUS = 1'b0,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gmii_rxdv,
    input  logic [7:0]       gmii_rxd,
    input  logic [47:0]      self_mac,
    input  logic [31:0]      self_ip,
    output logic             arp_valid,
    input  logic             arp_ready,
    output logic             arp_op,
    output logic             arp_grat,
    output logic [47:0]      arp_src_mac,
    output logic [31:0]      arp_src_ip,
    output logic [CNT_W-1:0] rx_ok_cnt,
    output logic [CNT_W-1:0] rx_drop_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    logic [4:0]  cnt;
    logic [47:0] sr;
    logic        op_r;
    logic        grat_r;
    logic [47:0] mac_r;
    logic [31:0] ip_r;

    logic [15:0] w16;
    logic [31:0] w32;
    logic [47:0] w48;
    logic        bad;
    logic        to_vlan;
    logic        grat_n;
    logic        in_frame;
    logic        drop_ev;
    logic        commit;
    logic        pop_fire;
    logic        ok_ev;
    logic        ovf_ev;
    logic        q_full;
    logic        q_empty;
    arp_entry_t  wr_entry;
    arp_entry_t  head;

    // Multi-byte fields ending on the current byte.
    assign w16 = {sr[7:0], gmii_rxd};
    assign w32 = {sr[23:0], gmii_rxd};
    assign w48 = {sr[39:0], gmii_rxd};

    always_comb begin
        bad     = 1'b0;
        to_vlan = 1'b0;
        grat_n  = 1'b0;
        unique case (state)
            ETH_HEAD: begin
                if (cnt == 5'd6 && sr != self_mac
                    && sr != ETH_BCAST_MAC)
                    bad = 1'b1;
                if (cnt == 5'd13) begin
                    if (ACCEPT_VLAN && w16 == ETH_TYPE_VLAN)
                        to_vlan = 1'b1;
                    else if (w16 != ETH_TYPE_ARP)
                        bad = 1'b1;
                end
            end
            VLAN:
                bad = (cnt == 5'd3) && (w16 != ETH_TYPE_ARP);
            ARP_DATA: begin
                case (cnt)
                    5'd1:  bad = (w16 != ARP_HTYPE_ETH);
                    5'd3:  bad = (w16 != ARP_PTYPE_IPV4);
                    5'd4:  bad = (gmii_rxd != ARP_HLEN);
                    5'd5:  bad = (gmii_rxd != ARP_PLEN);
                    5'd7:  bad = (w16 != ARP_OP_REQ)
                              && (w16 != ARP_OP_REPLY);
                    5'd27: begin
                        if (w32 == self_ip)
                            grat_n = 1'b0;
                        else if (ACCEPT_GRATUITOUS && w32 == ip_r)
                            grat_n = 1'b1;
                        else
                            bad = 1'b1;
                    end
                    default: bad = 1'b0;
                endcase
            end
            default: bad = 1'b0;
        endcase
    end

    assign in_frame = (state == ETH_HEAD) || (state == VLAN)
                   || (state == ARP_DATA);
    assign drop_ev  = in_frame && (!gmii_rxdv || bad);
    assign commit   = (state == WAIT_EOF) && !gmii_rxdv;
    assign pop_fire = arp_valid && arp_ready;
    assign ok_ev    = commit && (!q_full || pop_fire);
    assign ovf_ev   = commit && q_full && !pop_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            op_r   <= 1'b0;
            grat_r <= 1'b0;
            mac_r  <= '0;
            ip_r   <= '0;
        end else begin
            if (gmii_rxdv)
                sr <= w48;
            unique case (state)
                IDLE: begin
                    if (gmii_rxdv && gmii_rxd == PRE_BYTE) begin
                        state <= PREAMBLE;
                        cnt   <= '0;
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rxdv)
                        state <= IDLE;
                    else if (cnt != 5'd6) begin
                        if (gmii_rxd == PRE_BYTE)
                            cnt <= cnt + 5'd1;
                        else
                            state <= IDLE;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state <= ETH_HEAD;
                        cnt   <= '0;
                    end else
                        state <= IDLE;
                end
                ETH_HEAD: begin
                    if (!gmii_rxdv)
                        state <= IDLE;
                    else if (bad)
                        state <= DISCARD;
                    else if (cnt == 5'd13) begin
                        state <= to_vlan ? VLAN : ARP_DATA;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 5'd1;
                end
                VLAN: begin
                    if (!gmii_rxdv)
                        state <= IDLE;
                    else if (bad)
                        state <= DISCARD;
                    else if (cnt == 5'd3) begin
                        state <= ARP_DATA;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 5'd1;
                end
                ARP_DATA: begin
                    if (!gmii_rxdv)
                        state <= IDLE;
                    else if (bad)
                        state <= DISCARD;
                    else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7)
                            op_r <= (w16 == ARP_OP_REPLY);
                        if (cnt == 5'd13)
                            mac_r <= w48;
                        if (cnt == 5'd17)
                            ip_r <= w32;
                        if (cnt == 5'd27) begin
                            grat_r <= grat_n;
                            state  <= WAIT_EOF;
                        end
                    end
                end
                WAIT_EOF, DISCARD: begin
                    if (!gmii_rxdv)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ok_cnt   <= '0;
            rx_drop_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            if (ok_ev && rx_ok_cnt != CNT_MAX)
                rx_ok_cnt <= rx_ok_cnt + CNT_ONE;
            if (drop_ev && rx_drop_cnt != CNT_MAX)
                rx_drop_cnt <= rx_drop_cnt + CNT_ONE;
            if (ovf_ev && ovf_cnt != CNT_MAX)
                ovf_cnt <= ovf_cnt + CNT_ONE;
        end
    end

    assign wr_entry = '{op: op_r, grat: grat_r,
                        mac: mac_r, ip: ip_r};

    arp_entry_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (commit),
        .wdata (wr_entry),
        .pop   (arp_ready),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign arp_valid   = !q_empty;
    assign arp_op      = head.op;
    assign arp_grat    = head.grat;
    assign arp_src_mac = head.mac;
    assign arp_src_ip  = head.ip;

endmodule

// File: tb/tb_arp_rx_q.sv
// Bench for arp_rx_q: two parameter sets share one GMII stream and are
// compared against a frame-level model of the accept/drop/queue rules.
module tb_arp_rx_q;
    import arp_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] MY_IP  = 32'hC0A8_0102;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxdv;
    logic [7:0]  rxd;
    logic [47:0] self_mac;
    logic [31:0] self_ip;
    logic        ready_a, ready_b;

    logic        valid_a, op_a, grat_a;
    logic [47:0] mac_a;
    logic [31:0] ip_a;
    logic [15:0] ok_a, drop_a, ovf_a;
    logic        valid_b, op_b, grat_b;
    logic [47:0] mac_b;
    logic [31:0] ip_b;
    logic [2:0]  ok_b, drop_b, ovf_b;

    always #5 clk = ~clk;

    arp_rx_q #(.QUEUE_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .gmii_rxdv(rxdv), .gmii_rxd(rxd),
        .self_mac(self_mac), .self_ip(self_ip),
        .arp_valid(valid_a), .arp_ready(ready_a), .arp_op(op_a),
        .arp_grat(grat_a), .arp_src_mac(mac_a), .arp_src_ip(ip_a),
        .rx_ok_cnt(ok_a), .rx_drop_cnt(drop_a), .ovf_cnt(ovf_a)
    );

    arp_rx_q #(
        .QUEUE_DEPTH(DEPTH), .ACCEPT_VLAN(1'b0),
        .ACCEPT_GRATUITOUS(1'b1), .CNT_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .gmii_rxdv(rxdv), .gmii_rxd(rxd),
        .self_mac(self_mac), .self_ip(self_ip),
        .arp_valid(valid_b), .arp_ready(ready_b), .arp_op(op_b),
        .arp_grat(grat_b), .arp_src_mac(mac_b), .arp_src_ip(ip_b),
        .rx_ok_cnt(ok_b), .rx_drop_cnt(drop_b), .ovf_cnt(ovf_b)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] fr[$];
    arp_entry_t mqa[$];
    arp_entry_t mqb[$];
    int oka, dra, ova, okb, drb, ovb;
    logic v_at_fall;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return 64'(n > m ? m : n);
    endfunction

    function automatic logic [47:0] getn(input int p, input int n);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[39:0], fr[p+i]};
        return v;
    endfunction

    task automatic put(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
    endtask

    task automatic build(input logic [47:0] da, input bit vlan,
                         input logic [15:0] etype, input logic [15:0] ptype,
                         input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa,
                         input int pad);
        fr.delete();
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        put(da, 6);
        put({16'h0200, 32'($urandom)}, 6);
        if (vlan) begin
            put(48'h8100, 2);
            put(48'h0005, 2);
        end
        put(48'(etype), 2);
        put(48'h0001, 2);
        put(48'(ptype), 2);
        put(48'h0604, 2);
        put(48'(oper), 2);
        put(sha, 6);
        put(48'(spa), 4);
        put({16'h0, 32'($urandom)}, 6);
        put(48'(tpa), 4);
        for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
    endtask

    // 0 = not a frame (preamble), 1 = dropped, 2 = accepted into e
    function automatic int classify(input bit vok, input bit gok,
                                    output arp_entry_t e);
        int p;
        logic [15:0] t, oper;
        logic [31:0] spa, tpa;
        logic [47:0] da;
        e = '0;
        if (fr.size() < 8) return 0;
        for (int i = 0; i < 7; i++) if (fr[i] != 8'h55) return 0;
        if (fr[7] != 8'hD5) return 0;
        if (fr.size() < 22) return 1;
        da = getn(8, 6);
        if (da != MY_MAC && da != BCAST) return 1;
        t = 16'(getn(20, 2));
        p = 22;
        if (t == 16'h8100) begin
            if (!vok || fr.size() < 26) return 1;
            t = 16'(getn(24, 2));
            p = 26;
        end
        if (t != 16'h0806 || fr.size() < p + 28) return 1;
        if (getn(p, 2) != 48'h0001 || getn(p + 2, 2) != 48'h0800) return 1;
        if (fr[p+4] != 8'd6 || fr[p+5] != 8'd4) return 1;
        oper = 16'(getn(p + 6, 2));
        if (oper != 16'd1 && oper != 16'd2) return 1;
        spa = 32'(getn(p + 14, 4));
        tpa = 32'(getn(p + 24, 4));
        e.op  = (oper == 16'd2);
        e.mac = getn(p + 8, 6);
        e.ip  = spa;
        if (tpa == MY_IP) return 2;
        if (gok && spa == tpa) begin
            e.grat = 1'b1;
            return 2;
        end
        return 1;
    endfunction

    task automatic model_step(input bit pa, input bit pb);
        arp_entry_t e;
        int r;
        if (pa && mqa.size() > 0) void'(mqa.pop_front());
        if (pb && mqb.size() > 0) void'(mqb.pop_front());
        r = classify(1'b1, 1'b0, e);
        if (r == 1) dra++;
        else if (r == 2) begin
            if (mqa.size() < DEPTH) begin
                mqa.push_back(e);
                oka++;
            end else ova++;
        end
        r = classify(1'b0, 1'b1, e);
        if (r == 1) drb++;
        else if (r == 2) begin
            if (mqb.size() < DEPTH) begin
                mqb.push_back(e);
                okb++;
            end else ovb++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the EOF cycle.
    task automatic send(input bit pa, input bit pb);
        for (int i = 0; i < fr.size(); i++) begin
            rxdv = 1'b1;
            rxd  = fr[i];
            @(negedge clk);
        end
        rxdv      = 1'b0;
        rxd       = 8'h00;
        ready_a   = pa;
        ready_b   = pb;
        v_at_fall = valid_a;
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
        model_step(pa, pb);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a.valid"}, 64'(valid_a), 64'(mqa.size() != 0));
        if (mqa.size() != 0) begin
            chk({tag, " a.op"},   64'(op_a),   64'(mqa[0].op));
            chk({tag, " a.grat"}, 64'(grat_a), 64'(mqa[0].grat));
            chk({tag, " a.mac"},  64'(mac_a),  64'(mqa[0].mac));
            chk({tag, " a.ip"},   64'(ip_a),   64'(mqa[0].ip));
        end
        chk({tag, " a.ok"},   64'(ok_a),   sat(oka, 16));
        chk({tag, " a.drop"}, 64'(drop_a), sat(dra, 16));
        chk({tag, " a.ovf"},  64'(ovf_a),  sat(ova, 16));
        chk({tag, " b.valid"}, 64'(valid_b), 64'(mqb.size() != 0));
        if (mqb.size() != 0) begin
            chk({tag, " b.op"},   64'(op_b),   64'(mqb[0].op));
            chk({tag, " b.grat"}, 64'(grat_b), 64'(mqb[0].grat));
            chk({tag, " b.mac"},  64'(mac_b),  64'(mqb[0].mac));
            chk({tag, " b.ip"},   64'(ip_b),   64'(mqb[0].ip));
        end
        chk({tag, " b.ok"},   64'(ok_b),   sat(okb, 3));
        chk({tag, " b.drop"}, 64'(drop_b), sat(drb, 3));
        chk({tag, " b.ovf"},  64'(ovf_b),  sat(ovb, 3));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " a.outs"},
            64'({valid_a, op_a, grat_a, mac_a, ip_a} != '0), 64'(0));
        chk({tag, " a.cnts"}, 64'({ok_a, drop_a, ovf_a}), 64'(0));
        chk({tag, " b.outs"},
            64'({valid_b, op_b, grat_b, mac_b, ip_b} != '0), 64'(0));
        chk({tag, " b.cnts"}, 64'({ok_b, drop_b, ovf_b}), 64'(0));
    endtask

    task automatic drain(input string tag);
        bit pa, pb;
        while (mqa.size() > 0 || mqb.size() > 0) begin
            check_all({tag, " head"});
            pa = (mqa.size() > 0);
            pb = (mqb.size() > 0);
            ready_a = pa;
            ready_b = pb;
            @(negedge clk);
            ready_a = 1'b0;
            ready_b = 1'b0;
            if (pa) void'(mqa.pop_front());
            if (pb) void'(mqb.pop_front());
        end
        check_all({tag, " empty"});
    endtask

    task automatic model_clear();
        mqa.delete();
        mqb.delete();
        oka = 0; dra = 0; ova = 0;
        okb = 0; drb = 0; ovb = 0;
    endtask

    initial begin
        logic [47:0] sha, da;
        logic [31:0] spa, tpa;
        logic [15:0] oper, ptype;
        bit vlan;
        int pad, kind, k, n;

        model_clear();
        rst_n = 1'b0; rxdv = 1'b0; rxd = 8'h00;
        ready_a = 1'b0; ready_b = 1'b0;
        self_mac = MY_MAC; self_ip = MY_IP;
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Broadcast request to us
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd1, 48'h02_00_00_00_00_AA,
              32'hC0A8_0105, MY_IP, 18);
        send(0, 0);
        chk("req valid_at_fall", 64'(v_at_fall), 64'(0));
        chk("req valid", 64'(valid_a), 64'(1));
        chk("req mac", 64'(mac_a), 64'(48'h02_00_00_00_00_AA));
        chk("req ip", 64'(ip_a), 64'(32'hC0A8_0105));
        chk("req op", 64'({op_a, grat_a}), 64'(0));
        check_all("req");
        drain("req");

        // VLAN-tagged: a accepts, b rejects
        build(BCAST, 1, 16'h0806, 16'h0800, 16'd1, 48'h02_00_00_00_00_AA,
              32'hC0A8_0105, MY_IP, 4);
        send(0, 0);
        chk("vlan b.drop", 64'(drop_b), 64'(1));
        check_all("vlan");
        drain("vlan");

        build(MY_MAC, 0, 16'h0806, 16'h86DD, 16'd2, 48'h0200_0000_00BB,
              32'hC0A8_0107, MY_IP, 0);
        send(0, 0);
        check_all("ptype");
        build(MY_MAC, 0, 16'h0806, 16'h0800, 16'd3, 48'h0200_0000_00BB,
              32'hC0A8_0107, MY_IP, 0);
        send(0, 0);
        check_all("oper3");
        build(48'h02_11_22_33_44_55, 0, 16'h0806, 16'h0800, 16'd2,
              48'h0200_0000_00BB, 32'hC0A8_0107, MY_IP, 0);
        send(0, 0);
        chk("da a.drop", 64'(drop_a), 64'(3));
        check_all("da");
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd1, 48'h0200_0000_00AA,
              32'hC0A8_0105, MY_IP, 0);
        fr[3] = 8'h54;
        send(0, 0);
        check_all("preamble");

        // Gratuitous: only b accepts, flagged grat
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd1, 48'h0200_0000_00CC,
              32'hC0A8_0109, 32'hC0A8_0109, 2);
        send(0, 0);
        chk("grat b.grat", 64'(grat_b), 64'(1));
        check_all("grat");
        drain("grat");

        // DEPTH+2 good frames with no consumer, back-to-back
        for (int i = 0; i < DEPTH + 2; i++) begin
            build(MY_MAC, 0, 16'h0806, 16'h0800, 16'(1 + (i % 2)),
                  {16'h0200, 32'($urandom)}, {16'hC0A8, 16'(i)},
                  MY_IP, $urandom_range(0, 6));
            send(0, 0);
            check_all("fill");
        end
        chk("fill a.ovf", 64'(ovf_a), 64'(2));
        // Commit coincides with a pop while full
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd2, 48'h0200_0000_0077,
              32'hC0A8_0177, MY_IP, 0);
        send(1, 1);
        check_all("pop+push");
        drain("fill");

        // Truncated at ARP byte 20
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd1, 48'h0200_0000_00AA,
              32'hC0A8_0105, MY_IP, 0);
        while (fr.size() > 8 + 14 + 20) void'(fr.pop_back());
        send(0, 0);
        check_all("trunc");

        // Reset mid-frame with an entry queued
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd1, 48'h0200_0000_00AA,
              32'hC0A8_0105, MY_IP, 0);
        send(0, 0);
        for (int i = 0; i < 30; i++) begin
            rxdv = 1'b1;
            rxd  = fr[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        rxd = fr[30];
        @(negedge clk);
        rxd = fr[31];
        @(negedge clk);
        reset_check("midreset");
        rst_n = 1'b1;
        rxdv = 1'b0;
        @(negedge clk);
        model_clear();
        build(BCAST, 0, 16'h0806, 16'h0800, 16'd2, 48'h0200_0000_00DD,
              32'hC0A8_0111, MY_IP, 3);
        send(0, 0);
        check_all("post-reset");
        drain("post-reset");

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            kind  = $urandom_range(0, 8);
            da    = $urandom_range(0, 1) ? BCAST : MY_MAC;
            vlan  = 0;
            ptype = 16'h0800;
            oper  = 16'($urandom_range(1, 2));
            sha   = {16'h0200, 32'($urandom)};
            spa   = {16'hC0A8, 16'($urandom)};
            tpa   = MY_IP;
            pad   = $urandom_range(0, 18);
            case (kind)
                1: da = 48'h02_11_22_33_44_55;
                2: vlan = 1;
                3: ptype = 16'h86DD;
                4: oper = 16'd3;
                5: begin spa = 32'hC0A8_0109; tpa = spa; end
                8: tpa = 32'hC0A8_0177;
                default: ;
            endcase
            build(da, vlan, 16'h0806, ptype, oper, sha, spa, tpa, pad);
            if (kind == 6) begin
                n = $urandom_range(8, 49);
                while (fr.size() > n) void'(fr.pop_back());
            end
            if (kind == 7) begin
                k = $urandom_range(0, 7);
                fr[k] = (k == 7) ? 8'h5D : 8'h54;
            end
            send($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            check_all("rand");
            if ($urandom_range(0, 2) == 0) drain("rand");
        end
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
